fetcher_luma16x16: RTL and testbench

// Read-back side of the luma 16x16 intra residue store. Given a macroblock

---
 rtl/fetcher_luma16x16.sv | 182 ++++++++++++++++++
 tb/tb_fetcher_luma16x16.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher_luma16x16.sv
// Luma 16x16 residue read-back: fetches an MB's prediction mode, then
// streams its residues in raster order through a 2-entry valid/ready FIFO.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   start, mbnumber        fetch request (taken only when idle)
//   busy, err              fetch in progress; out-of-range start pulse
//   mode_rd_en, mode_addr  mode RAM read port (1-cycle latency)
//   mode_rdata             mode RAM read data
//   res_rd_en, res_addr    residue RAM read port (1-cycle latency)
//   res_rdata              residue RAM read data
//   mode, mode_valid       captured prediction mode
//   out_valid, out_ready   residue stream handshake
//   out_data, out_last     residue byte; final beat marker
module fetcher_luma16x16 #(
  parameter int LENGTH    = 1280,
  parameter int WIDTH     = 720,
  parameter int MB_SIZE_L = 16,
  parameter int MB_SIZE_W = 16,
  parameter int ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [12:0]       mbnumber,
  output logic              busy,
  output logic              err,
  output logic              mode_rd_en,
  output logic [12:0]       mode_addr,
  input  logic [2:0]        mode_rdata,
  output logic              res_rd_en,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [7:0]        res_rdata,
  output logic [2:0]        mode,
  output logic              mode_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  localparam int MBX  = LENGTH / MB_SIZE_L;
  localparam int NMB  = MBX * (WIDTH / MB_SIZE_W);
  localparam int NPIX = MB_SIZE_L * MB_SIZE_W;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int JW   = $clog2(MB_SIZE_L);

  localparam logic [12:0]     NMB_C  = 13'(NMB);
  localparam logic [12:0]     MBX_C  = 13'(MBX);
  localparam logic [CW-1:0]   NPIX_C = CW'(NPIX);
  localparam logic [JW-1:0]   JMAX   = JW'(MB_SIZE_L - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(LENGTH);
  localparam logic [ADDR_W-1:0] MB_ROW_STEP = ADDR_W'(MB_SIZE_W * LENGTH);
  localparam logic [ADDR_W-1:0] MB_COL_STEP = ADDR_W'(MB_SIZE_L);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MODE_RD  = 2'd1;
  localparam logic [1:0] S_MODE_CAP = 2'd2;
  localparam logic [1:0] S_STREAM   = 2'd3;

  logic [1:0]        state;
  logic [12:0]       mb_q;
  logic [ADDR_W-1:0] mbx_a;
  logic [ADDR_W-1:0] mby_a;
  logic [ADDR_W-1:0] base_calc;
  logic [ADDR_W-1:0] row_base;
  logic [JW-1:0]     col;
  logic [CW-1:0]     issued;
  logic              inflight;
  logic              inflight_last;
  logic [8:0]        fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop;
  logic              issue;

  // MB origin: one constant divide on the latched index.
  always_comb begin
    mby_a     = ADDR_W'(mb_q / MBX_C);
    mbx_a     = ADDR_W'(mb_q % MBX_C);
    base_calc = mby_a * MB_ROW_STEP + mbx_a * MB_COL_STEP;
  end

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr][7:0] : 8'd0;
  assign out_last  = out_valid ? fifo_mem[rd_ptr][8] : 1'b0;

  // Credit counts the slot freed by a pop this cycle, so a
  // continuously-ready sink sees one beat per cycle.
  assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = (state == S_STREAM) && (issued != NPIX_C) &&
                 (occ < 3'd2);

  assign res_rd_en = issue;
  assign res_addr  = row_base + ADDR_W'(col);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      mb_q          <= '0;
      busy          <= 1'b0;
      err           <= 1'b0;
      mode_rd_en    <= 1'b0;
      mode_addr     <= '0;
      mode          <= '0;
      mode_valid    <= 1'b0;
      row_base      <= '0;
      col           <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (mbnumber < NMB_C) begin
              mb_q       <= mbnumber;
              mode_addr  <= mbnumber;
              mode_rd_en <= 1'b1;
              busy       <= 1'b1;
              mode_valid <= 1'b0;
              state      <= S_MODE_RD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_MODE_RD: begin
          mode_rd_en <= 1'b0;
          row_base   <= base_calc;
          col        <= '0;
          issued     <= '0;
          state      <= S_MODE_CAP;
        end
        S_MODE_CAP: begin
          mode       <= mode_rdata;
          mode_valid <= 1'b1;
          state      <= S_STREAM;
        end
        S_STREAM: begin
          if (pop && out_last) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        issued <= issued + CW'(1);
        if (col == JMAX) begin
          col      <= '0;
          row_base <= row_base + ROW_STRIDE;
        end else begin
          col <= col + JW'(1);
        end
      end

      inflight      <= issue;
      inflight_last <= issue && (issued == NPIX_C - CW'(1));

      if (inflight)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (inflight)
      fifo_mem[wr_ptr] <= {inflight_last, res_rdata};
  end

endmodule

// File: tb/tb_fetcher_luma16x16.sv
// Bench for fetcher_luma16x16: RAM models, reference address/data model,
// queue scoreboard with a negedge monitor, random backpressure.
module tb_fetcher_luma16x16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] mbnumber;
  logic        busy;
  logic        err;
  logic        mode_rd_en;
  logic [12:0] mode_addr;
  logic [2:0]  mode_rdata;
  logic        res_rd_en;
  logic [19:0] res_addr;
  logic [7:0]  res_rdata;
  logic [2:0]  mode;
  logic        mode_valid;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  fetcher_luma16x16 dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
    .busy(busy), .err(err),
    .mode_rd_en(mode_rd_en), .mode_addr(mode_addr),
    .mode_rdata(mode_rdata),
    .res_rd_en(res_rd_en), .res_addr(res_addr), .res_rdata(res_rdata),
    .mode(mode), .mode_valid(mode_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int duty = 100;

  // reference content of the two RAMs
  function automatic logic [7:0] res_val(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ 8'h3C;
  endfunction

  function automatic logic [2:0] mode_val(input int mb);
    return 3'((mb * 3 + 2) % 8);
  endfunction

  always @(posedge clk) begin
    if (mode_rd_en) mode_rdata <= mode_val(int'(mode_addr));
    if (res_rd_en)  res_rdata  <= res_val(32'(res_addr));
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // scoreboard queues
  int          exp_addr  [$];
  logic [8:0]  exp_beat  [$];
  logic [2:0]  exp_mode  [$];
  int          exp_maddr [$];

  task automatic push_mb(input int mb);
    int mbx, mby, i, j, a;
    mbx = mb % 80;
    mby = mb / 80;
    exp_maddr.push_back(mb);
    exp_mode.push_back(mode_val(mb));
    for (int k = 0; k < 256; k++) begin
      i = k / 16;
      j = k % 16;
      a = (mby * 16 + i) * 1280 + mbx * 16 + j;
      exp_addr.push_back(a);
      exp_beat.push_back({(k == 255), res_val(32'(a))});
    end
  endtask

  // monitor state
  int         beat_k = 0;
  int         rd_idx = 0;
  int         outstanding = 0;
  int         cyc = 0;
  int         t0 = 0;
  int         first_addr = -1;
  int         last_addr = -1;
  logic       last_done = 1'b0;
  logic       stalled = 1'b0;
  logic       prev_mv = 1'b0;
  logic [8:0] held = '0;

  always @(negedge clk) begin
    if (reset) begin
      beat_k = 0; rd_idx = 0; outstanding = 0;
      last_done = 1'b0; stalled = 1'b0; prev_mv = 1'b0;
    end else begin
      cyc++;
      if (last_done) begin
        chk("busy_fall", {busy, out_valid}, 0);
        last_done = 1'b0;
      end
      if (mode_rd_en) begin
        if (exp_maddr.size() == 0) chk("mode_rd_unexp", 1, 0);
        else chk("mode_addr", mode_addr, exp_maddr.pop_front());
      end
      if (mode_valid && !prev_mv) begin
        if (exp_mode.size() == 0) chk("mode_unexp", 1, 0);
        else chk("mode", mode, exp_mode.pop_front());
      end
      prev_mv = mode_valid;
      if (stalled)
        chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, held});
      if (res_rd_en) begin
        if (rd_idx == 0) first_addr = int'(res_addr);
        if (rd_idx == 255) last_addr = int'(res_addr);
        rd_idx = (rd_idx + 1) % 256;
        outstanding++;
        if (exp_addr.size() == 0) chk("res_rd_unexp", 1, 0);
        else chk("res_addr", res_addr, exp_addr.pop_front());
      end
      if (out_valid && out_ready) begin
        if (beat_k == 0) t0 = cyc;
        if (exp_beat.size() == 0) chk("beat_unexp", 1, 0);
        else chk("beat", {out_last, out_data}, exp_beat.pop_front());
        outstanding--;
        if (out_last) begin
          if (duty == 100) chk("throughput", cyc - t0, 255);
          last_done = 1'b1;
          beat_k = 0;
        end else begin
          beat_k++;
        end
      end
      if (res_rd_en || (out_valid && out_ready))
        chk("outstanding_le2", outstanding <= 2, 1);
      stalled = out_valid && !out_ready;
      held = {out_last, out_data};
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 99) < duty);
    end
  end

  task automatic check_zero(input string name);
    chk(name, {busy, err, mode_rd_en, mode_addr, res_rd_en, res_addr,
               mode, mode_valid, out_valid, out_data, out_last}, 0);
  endtask

  task automatic run_mb(input int mb, input int poke);
    int n;
    push_mb(mb);
    @(posedge clk); #1;
    start = 1'b1;
    mbnumber = 13'(mb);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 5000) begin
      if (poke != 0 && n == 50) begin
        start = 1'b1;
        mbnumber = 13'(poke);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (n >= 5000 || n < 256) begin
      errors++;
      $display("FAIL run_len mb=%0d: busy cycles %0d outside 256..4999",
               mb, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    mbnumber = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: MB 0, full rate
    duty = 100;
    run_mb(0, 0);
    chk("mb0_first", first_addr, 0);
    chk("mb0_last", last_addr, 19215);

    // 2: MB 81
    run_mb(81, 0);
    chk("mb81_first", first_addr, 20496);
    chk("mb81_last", last_addr, 39711);

    // 3: last MB, then out of range
    run_mb(3599, 0);
    chk("mb3599_last", last_addr, 921599);
    @(posedge clk); #1;
    start = 1'b1;
    mbnumber = 13'd3600;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_pulse", {err, busy, mode_rd_en, res_rd_en}, 4'b1000);
    @(negedge clk);
    chk("err_clear", {err, busy, mode_rd_en, res_rd_en}, 4'b0000);

    // 4: random backpressure
    duty = 30;
    for (int i = 0; i < 4; i++)
      run_mb(int'($urandom_range(0, 3599)), 0);

    // 6: start while streaming is ignored
    duty = 60;
    run_mb(200, 7);
    duty = 100;
    run_mb(1234, 3000);

    // 5: reset mid-stream
    duty = 100;
    push_mb(40);
    @(posedge clk); #1;
    start = 1'b1;
    mbnumber = 13'd40;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (beat_k < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_beat100", n < 2000, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_addr.delete();
    exp_beat.delete();
    exp_mode.delete();
    exp_maddr.delete();
    @(negedge clk);
    check_zero("reset_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    duty = 50;
    run_mb(5, 0);

    chk("queues_empty", exp_addr.size() + exp_beat.size() +
        exp_mode.size() + exp_maddr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
